// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO and models mult/div latency with a
// down-counting busy timer so the hazard controller can stall the D stage.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no operation in flight; mthi/mtlo and new mult/div accepted
//   S_RUN  | mult/div in flight; counter runs down, HI/LO written at count 1
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic        start,
    input  logic        req,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          is_md;
    logic          accept;
    logic          issue;
    logic          done;

    logic [63:0]   prod_s, prod_u;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, b_safe, bu_safe;
    logic [31:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign is_md  = (op >= OP_MULT) && (op <= OP_DIVU);
    assign accept = start && !req && (state_q == S_IDLE);
    assign issue  = accept && is_md;
    assign done   = (state_q == S_RUN) && (cnt_q == CNT_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_RUN;
            S_RUN:   if (done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Division works on magnitudes so the INT_MIN / -1 case falls out naturally.
    always_comb begin
        prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u  = {32'b0, a_q} * {32'b0, b_q};
        a_neg   = a_q[31];
        b_neg   = b_q[31];
        a_mag   = a_neg ? (32'd0 - a_q) : a_q;
        b_mag   = b_neg ? (32'd0 - b_q) : b_q;
        b_safe  = (b_q == 32'd0) ? 32'd1 : b_mag;
        bu_safe = (b_q == 32'd0) ? 32'd1 : b_q;
        q_mag   = a_mag / b_safe;
        r_mag   = a_mag % b_safe;
        q_s     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r_s     = a_neg ? (32'd0 - r_mag) : r_mag;
        q_u     = a_q / bu_safe;
        r_u     = a_q % bu_safe;
    end

    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (issue) begin
            op_d  = op;
            a_d   = rs_val;
            b_d   = rt_val;
            cnt_d = (op == OP_MULT || op == OP_MULTU) ? MULT_LD : DIV_LD;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        if (done) begin
            case (op_q)
                OP_MULT:  {hi_d, lo_d} = prod_s;
                OP_MULTU: {hi_d, lo_d} = prod_u;
                OP_DIV:   if (b_q != 32'd0) begin hi_d = r_s; lo_d = q_s; end
                OP_DIVU:  if (b_q != 32'd0) begin hi_d = r_u; lo_d = q_u; end
                default:  ;
            endcase
        end else if (accept && op == OP_MTHI) begin
            hi_d = rs_val;
        end else if (accept && op == OP_MTLO) begin
            lo_d = rs_val;
        end
    end

    always_comb begin
        busy      = (state_q == S_RUN);
        stall_req = busy || (start && is_md);
        hi        = hi_q;
        lo        = lo_q;
        case (op)
            OP_MFHI: rd_data = hi_q;
            OP_MFLO: rd_data = lo_q;
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized + directed bench for mdu_unit against a cycle-level reference
// model that computes results with plain 64-bit integer arithmetic.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic        start;
    logic        req;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_seen = 0;

    // reference model state
    logic [31:0] m_hi = 0, m_lo = 0;
    int          m_left = 0;
    logic        p_wr = 0;
    logic [31:0] p_hi = 0, p_lo = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op(op), .start(start), .req(req),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] o, input logic s, input logic r,
                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] p;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_wr = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (s && !r) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (o)
                4'd1: begin p = 64'(sa * sb); p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1; m_left = 5; end
                4'd2: begin p = {32'b0, a} * {32'b0, b}; p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1; m_left = 5; end
                4'd3: begin
                    p_wr = (b != 0); m_left = 10;
                    if (b != 0) begin q = sa / sb; rm = sa % sb; p_lo = 32'(q); p_hi = 32'(rm); end
                end
                4'd4: begin
                    p_wr = (b != 0); m_left = 10;
                    if (b != 0) begin p_lo = a / b; p_hi = a % b; end
                end
                4'd5: m_hi = a;
                4'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input logic rst, input logic [3:0] o, input logic s, input logic r,
                       input logic [31:0] a, input logic [31:0] b);
        logic exp_stall;
        reset = rst; op = o; start = s; req = r; rs_val = a; rt_val = b;
        #3;
        if (!rst) begin
            exp_stall = (m_left > 0) || (s && o >= 4'd1 && o <= 4'd4);
            chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
            chk("stall_req", {31'b0, stall_req}, {31'b0, exp_stall});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("rd_data", rd_data, (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'd0);
        end
        if (busy === 1'b1) busy_seen++;
        @(posedge clk);
        model_edge(rst, o, s, r, a, b);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'd0, 0, 0, 32'd0, 32'd0);
    endtask

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF9};

    function automatic logic [31:0] pick();
        if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        cyc(1, 4'd0, 0, 0, 32'd0, 32'd0);
        cyc(1, 4'd0, 0, 0, 32'd0, 32'd0);

        // mult -2 * 3
        cyc(0, 4'd1, 1, 0, 32'hFFFFFFFE, 32'd3);
        busy_seen = 0;
        idle(7);
        chk("mult_busy_len", busy_seen, 5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        cyc(0, 4'd2, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        idle(6);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        cyc(0, 4'd3, 1, 0, 32'hFFFFFFF9, 32'd2);
        busy_seen = 0;
        idle(12);
        chk("div_busy_len", busy_seen, 10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        cyc(0, 4'd4, 1, 0, 32'd7, 32'd0);
        busy_seen = 0;
        idle(12);
        chk("divu0_busy_len", busy_seen, 10);
        chk("divu0_lo", lo, 32'hFFFFFFFD);
        chk("divu0_hi", hi, 32'hFFFFFFFF);

        cyc(0, 4'd5, 1, 0, 32'h12345678, 32'd0);
        cyc(0, 4'd7, 0, 0, 32'd0, 32'd0);
        chk("mfhi_after_mthi", rd_data, 32'h12345678);
        cyc(0, 4'd5, 1, 1, 32'hDEADBEEF, 32'd0);
        chk("mthi_req_hi", hi, 32'h12345678);

        // mtlo while busy is ignored
        cyc(0, 4'd1, 1, 0, 32'd3, 32'd4);
        cyc(0, 4'd6, 1, 0, 32'hCAFEF00D, 32'd0);
        idle(6);
        chk("mtlo_busy_lo", lo, 32'd12);
        chk("mtlo_busy_hi", hi, 32'd0);

        // reset on the 4th busy cycle of a divide
        cyc(0, 4'd3, 1, 0, 32'd100, 32'd7);
        idle(3);
        cyc(1, 4'd0, 0, 0, 32'd0, 32'd0);
        busy_seen = 0;
        idle(12);
        chk("rst_mid_busy", busy_seen, 0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);

        // req after issue does not cancel the in-flight mult
        cyc(0, 4'd1, 1, 0, 32'd6, 32'd7);
        cyc(0, 4'd5, 1, 1, 32'h55555555, 32'd0);
        idle(5);
        chk("req_after_lo", lo, 32'd42);
        chk("req_after_hi", hi, 32'd0);

        cyc(0, 4'd1, 1, 1, 32'd9, 32'd9);
        busy_seen = 0;
        idle(6);
        chk("req_same_busy", busy_seen, 0);
        chk("req_same_lo", lo, 32'd42);

        cyc(0, 4'd3, 1, 0, 32'h80000000, 32'hFFFFFFFF);
        idle(11);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(99) == 0), 4'($urandom_range(15)), ($urandom_range(3) != 0),
                ($urandom_range(5) == 0), pick(), pick());
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
